interp_sequencer: RTL and testbench
===================================

INTERP_SEQUENCER -- requirements
Module: interp_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 11, meaning the width of all cycle counters.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive in-tolerance input periods needed to assert locked.
REQ-003 SHALL have parameter LOCK_TOL, default 1, meaning the maximum allowed |period delta| in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port run, input, 1 bit: enables output tick generation and sequencing.
REQ-007 SHALL have port din_strobe, input, 1 bit: one-cycle input-sample strobe.
REQ-008 SHALL have port period_div, input, PERIOD_W bits: terminal count of the output tick divider (0x1FF gives 96 kHz from 49.152 MHz).
REQ-009 SHALL have port err_clr, input, 1 bit: clears overrun.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle output-sample tick.
REQ-011 SHALL have port phase_cnt, output, PERIOD_W bits: input-counter snapshot at tick (coefficient a).
REQ-012 SHALL have port period_cnt, output, PERIOD_W bits: last measured input period (maxCnt).
REQ-013 SHALL have the datapath control outputs sub_en, mult_en, mult_sel, add_en and dout_valid, each output and 1 bit.
REQ-014 SHALL have outputs locked and overrun, each 1 bit.

Function
REQ-015 Input counter SHALL increment every clk, saturating at all-ones.
- On din_strobe: period_cnt <= counter value that cycle; counter <= 0.
REQ-016 Tick divider, when run=1: counts 0..period_div, then wraps to 0.
- tick=1 for exactly the cycle in which it wraps.
- First tick occurs period_div+1 cycles after run rises.
REQ-017 On tick: phase_cnt <= input counter pre-clear value (a din_strobe in the same cycle does not affect the snapshot).
REQ-018 FSM states SHALL be IDLE -> SUB -> MUL1 -> MUL0 -> ADD -> VALID -> IDLE, one cycle each.
- IDLE exits only on tick.
- Sequence latency: dout_valid is high exactly 5 cycles after tick.
REQ-019 Per-state outputs:
- SUB: sub_en=1.
- MUL1: mult_en=1, mult_sel=0 (older sample x (period-a)).
- MUL0: mult_en=1, mult_sel=1 (newer sample x a).
- ADD: add_en=1.
- VALID: dout_valid=1.
- All other state/output combinations: 0.
REQ-020 A tick arriving while FSM is not IDLE SHALL be dropped and SHALL set sticky overrun.
- err_clr clears overrun.
- If set and clear occur in the same cycle, set wins.
REQ-021 Lock detection on each din_strobe, for |new period - previous period|:
- Delta <= LOCK_TOL: increments a match count, saturating at LOCK_COUNT.
- Otherwise: clears the match count.
- locked = (match count == LOCK_COUNT).
- A saturated period clears the match count.
REQ-022 run=0 SHALL synchronously clear the tick divider, force the FSM to IDLE and drive tick and all control outputs to 0.
- The period meter and lock detection continue running while run=0.
- run falling mid-sequence aborts the sequence with no dout_valid.

Reset
REQ-023 reset_n low SHALL asynchronously set:
- All counters, phase_cnt, period_cnt, the match count, locked, overrun and all control outputs to 0.
- The FSM to IDLE.

Configuration
REQ-024 With INTERP_SEQ_CLAMP_EN defined, phase_cnt SHALL be clamped to period_cnt when the snapshot exceeds it, so that period-a never underflows.
- Without the macro, phase_cnt SHALL carry the raw snapshot.

Structure
REQ-025 Shared package interp_pkg SHALL hold:
- The FSM state enum.
- The PERIOD_W default.
- The constant DIV_96K = 11'h1FF.
REQ-026 Input counter, period capture and lock detection SHALL live in the sub-module interp_period_meter.

Verification
REQ-027 Reset, then run=1 with period_div=0x1FF: tick at cycle 512, then every 512 cycles; dout_valid 5 cycles after each tick.
REQ-028 din_strobe every 1024 cycles: period_cnt=0x3FF; locked asserts at the 4th matching strobe.
- One period of 1030 deasserts locked.
REQ-029 Strobe period 1024 with tick coincident with counter=0x100: phase_cnt=0x100; strobe in the same cycle leaves phase_cnt=0x100.
REQ-030 period_div=2: second tick lands in MUL0 and is dropped; overrun=1 until err_clr; set wins over a simultaneous clear.
REQ-031 No din_strobe for 3000 cycles: counter saturates at 0x7FF.
- Next strobe gives period_cnt=0x7FF and locked=0.
- With INTERP_SEQ_CLAMP_EN, phase_cnt <= period_cnt.
REQ-032 run dropped in MUL1: all controls 0 next cycle, no dout_valid, FSM IDLE.
- reset_n pulsed mid-sequence clears all outputs immediately.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation sequencer.
package interp_pkg;

    localparam int unsigned PERIOD_W_DEF = 11;
    localparam logic [10:0] DIV_96K      = 11'h1FF;

    typedef enum logic [2:0] {
        StIdle,
        StSub,
        StMul1,
        StMul0,
        StAdd,
        StValid
    } seq_state_e;

endpackage

// File: rtl/interp_period_meter.sv
// Input period meter: free-running sample counter, period capture on strobe and lock detection.
module interp_period_meter
    import interp_pkg::*;
#(
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOCK_TOL   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                din_strobe,
    output logic [PERIOD_W-1:0] count,
    output logic [PERIOD_W-1:0] period,
    output logic                locked
);

    localparam int unsigned          MatchW   = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_W-1:0]  CntMax   = '1;
    localparam logic [MatchW-1:0]    MatchMax = MatchW'(LOCK_COUNT);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] delta;
    logic [MatchW-1:0]   match_q, match_d;

    always_comb begin
        cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        period_d = period_q;
        match_d  = match_q;
        delta    = (cnt_q >= period_q) ? cnt_q - period_q : period_q - cnt_q;
        if (din_strobe) begin
            cnt_d    = '0;
            period_d = cnt_q;
            // A saturated count means the real period is unknown, so never treat it as a match.
            if (cnt_q == CntMax || delta > PERIOD_W'(LOCK_TOL)) begin
                match_d = '0;
            end else if (match_q != MatchMax) begin
                match_d = match_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            match_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
        end
    end

    assign count  = cnt_q;
    assign period = period_q;
    assign locked = (match_q == MatchMax);

endmodule

// File: rtl/interp_sequencer.sv
// Interpolation sequencer: output tick divider, phase snapshot and datapath control FSM.
// Define INTERP_SEQ_CLAMP_EN to clamp the phase snapshot to the measured period.
module interp_sequencer
    import interp_pkg::*;
#(
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOCK_TOL   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                din_strobe,
    input  logic [PERIOD_W-1:0] period_div,
    input  logic                err_clr,
    output logic                tick,
    output logic [PERIOD_W-1:0] phase_cnt,
    output logic [PERIOD_W-1:0] period_cnt,
    output logic                sub_en,
    output logic                mult_en,
    output logic                mult_sel,
    output logic                add_en,
    output logic                dout_valid,
    output logic                locked,
    output logic                overrun
);

    logic [PERIOD_W-1:0] in_cnt;
    logic [PERIOD_W-1:0] snap;
    logic [PERIOD_W-1:0] div_q, div_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic                tick_q, tick_d;
    logic                overrun_q, overrun_d;
    seq_state_e          state_q, state_d;

    interp_period_meter #(
        .PERIOD_W   (PERIOD_W),
        .LOCK_COUNT (LOCK_COUNT),
        .LOCK_TOL   (LOCK_TOL)
    ) u_meter (
        .clk        (clk),
        .reset_n    (reset_n),
        .din_strobe (din_strobe),
        .count      (in_cnt),
        .period     (period_cnt),
        .locked     (locked)
    );

`ifdef INTERP_SEQ_CLAMP_EN
    assign snap = (in_cnt > period_cnt) ? period_cnt : in_cnt;
`else
    assign snap = in_cnt;
`endif

    // Tick is registered so the first one lands period_div+1 cycles after run rises.
    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if (run) begin
            if (div_q >= period_div) begin
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = tick_q ? snap : phase_q;
        overrun_d  = overrun_q;
        sub_en     = 1'b0;
        mult_en    = 1'b0;
        mult_sel   = 1'b0;
        add_en     = 1'b0;
        dout_valid = 1'b0;

        if (tick_q && state_q != StIdle) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle:  if (tick_q) state_d = StSub;
            StSub:   begin sub_en = 1'b1; state_d = StMul1; end
            StMul1:  begin mult_en = 1'b1; state_d = StMul0; end
            StMul0:  begin mult_en = 1'b1; mult_sel = 1'b1; state_d = StAdd; end
            StAdd:   begin add_en = 1'b1; state_d = StValid; end
            StValid: begin dout_valid = 1'b1; state_d = StIdle; end
            default: state_d = StIdle;
        endcase

        if (!run) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            phase_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= StIdle;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    assign tick      = tick_q;
    assign phase_cnt = phase_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_interp_sequencer.sv
// Self-checking bench for interp_sequencer against a cycle-count based reference model.
module tb_interp_sequencer;

    localparam int LOCK_COUNT = 4;
    localparam int LOCK_TOL   = 1;
    localparam int MAXC       = 2047;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        run = 1'b0;
    logic        din_strobe = 1'b0;
    logic [10:0] period_div = 11'd0;
    logic        err_clr = 1'b0;
    logic        tick;
    logic [10:0] phase_cnt;
    logic [10:0] period_cnt;
    logic        sub_en, mult_en, mult_sel, add_en, dout_valid;
    logic        locked, overrun;

    int errors = 0;
    int checks = 0;
    int cycle_n = 0;

    // Reference model: counter is "cycles since last strobe", tick schedule is arithmetic on
    // the number of consecutive run cycles, sequence position is "cycles since accepted tick".
    int m_since, m_period, m_match, m_run_edges, m_age, m_phase;
    bit m_tick, m_overrun;

    interp_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .din_strobe (din_strobe),
        .period_div (period_div),
        .err_clr    (err_clr),
        .tick       (tick),
        .phase_cnt  (phase_cnt),
        .period_cnt (period_cnt),
        .sub_en     (sub_en),
        .mult_en    (mult_en),
        .mult_sel   (mult_sel),
        .add_en     (add_en),
        .dout_valid (dout_valid),
        .locked     (locked),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic model_reset();
        m_since = 0; m_period = 0; m_match = 0; m_run_edges = 0;
        m_age = 0; m_phase = 0; m_tick = 0; m_overrun = 0;
    endtask

    task automatic model_edge();
        int cnt_pre, period_pre, age_pre, d, pd, snap;
        bit tick_pre;
        cnt_pre    = (m_since > MAXC) ? MAXC : m_since;
        period_pre = m_period;
        age_pre    = m_age;
        tick_pre   = m_tick;
        pd         = int'(period_div);

        if (din_strobe) begin
            d = cnt_pre - m_period;
            if (d < 0) d = -d;
            if (cnt_pre == MAXC || d > LOCK_TOL) m_match = 0;
            else if (m_match < LOCK_COUNT) m_match++;
            m_period = cnt_pre;
            m_since  = 0;
        end else begin
            m_since++;
        end

        if (run) m_run_edges++;
        else m_run_edges = 0;
        m_tick = run && (m_run_edges % (pd + 1) == 0);

        if (tick_pre) begin
            snap = cnt_pre;
`ifdef INTERP_SEQ_CLAMP_EN
            if (snap > period_pre) snap = period_pre;
`endif
            m_phase = snap;
        end

        if (tick_pre && age_pre != 0) m_overrun = 1;
        else if (err_clr) m_overrun = 0;

        if (!run) m_age = 0;
        else if (age_pre == 0) m_age = tick_pre ? 1 : 0;
        else if (age_pre == 5) m_age = 0;
        else m_age = age_pre + 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        cycle_n++;
        #1;
    endtask

    function automatic logic [29:0] obs_vec();
        return {tick, sub_en, mult_en, mult_sel, add_en, dout_valid, locked, overrun,
                phase_cnt, period_cnt};
    endfunction

    function automatic logic [29:0] exp_vec();
        logic [10:0] ph, pe;
        ph = 11'(m_phase);
        pe = 11'(m_period);
        return {m_tick, (m_age == 1), (m_age == 2 || m_age == 3), (m_age == 3), (m_age == 4),
                (m_age == 5), (m_match == LOCK_COUNT), m_overrun, ph, pe};
    endfunction

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 30'b0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs_vec(), 30'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ticks();
        int first_tick, first_valid;
        first_tick = -1;
        first_valid = -1;
        period_div = 11'h1FF;
        run = 1'b1;
        for (int k = 1; k <= 3 * 512 + 8; k++) begin
            cyc();
            if (tick === 1'b1 && first_tick < 0) first_tick = k;
            if (dout_valid === 1'b1 && first_valid < 0) first_valid = k;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ticks cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (first_tick != 512) begin
            errors++;
            $display("FAIL first_tick: got %0d want 512", first_tick);
        end
        checks++;
        if (first_valid != 517) begin
            errors++;
            $display("FAIL first_valid: got %0d want 517", first_valid);
        end
    endtask

    task automatic test_lock();
        for (int s = 0; s < 8; s++) begin
            din_strobe = 1'b1;
            cyc();
            din_strobe = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lock_strobe %0d: got %h want %h", s, obs_vec(), exp_vec());
            end
            if (s >= 1 && s <= 6) begin
                checks++;
                if (period_cnt !== 11'h3FF || locked !== (s >= 5)) begin
                    errors++;
                    $display("FAIL lock_seq %0d: got period=%h locked=%b want 3ff %b",
                             s, period_cnt, locked, (s >= 5));
                end
            end
            if (s == 7) begin
                checks++;
                if (period_cnt !== 11'd1030 || locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_lost: got period=%0d locked=%b want 1030 0",
                             period_cnt, locked);
                end
            end
            if (s < 7) begin
                for (int k = 0; k < ((s == 6) ? 1030 : 1023); k++) begin
                    cyc();
                    checks++;
                    if (obs_vec() !== exp_vec()) begin
                        errors++;
                        $display("FAIL lock_gap cyc %0d: got %h want %h",
                                 cycle_n, obs_vec(), exp_vec());
                    end
                end
            end
        end
    endtask

    task automatic test_phase();
        run = 1'b0;
        for (int k = 0; k < 400; k++) cyc();
        period_div = 11'd15;
        din_strobe = 1'b1;
        cyc();
        din_strobe = 1'b0;
        for (int k = 0; k < 'hF0; k++) cyc();
        run = 1'b1;
        for (int k = 0; k < 16; k++) cyc();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL phase_tick: got %b want 1", tick);
        end
        din_strobe = 1'b1;
        cyc();
        din_strobe = 1'b0;
        checks++;
        if (phase_cnt !== 11'h100 || period_cnt !== 11'h100) begin
            errors++;
            $display("FAIL phase_snap: got phase=%h period=%h want 100 100", phase_cnt, period_cnt);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL phase_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_overrun();
        run = 1'b0;
        err_clr = 1'b1;
        cyc();
        cyc();
        err_clr = 1'b0;
        period_div = 11'd2;
        run = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ovr_seq cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: got %b want 1", overrun);
        end
        run = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b want 1", overrun);
        end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr: got %b want 0", overrun);
        end
        run = 1'b1;
        err_clr = 1'b1;
        for (int k = 0; k < 7; k++) cyc();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_wins: got %b want 1", overrun);
        end
        cyc();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr_after: got %b want 0", overrun);
        end
        err_clr = 1'b0;
        run = 1'b0;
        cyc();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovr_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturate();
        period_div = 11'h1FF;
        run = 1'b1;
        din_strobe = 1'b1;
        cyc();
        din_strobe = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_gap cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
        end
        din_strobe = 1'b1;
        cyc();
        din_strobe = 1'b0;
        checks++;
        if (period_cnt !== 11'h7FF || locked !== 1'b0) begin
            errors++;
            $display("FAIL sat_period: got period=%h locked=%b want 7ff 0", period_cnt, locked);
        end
    endtask

    task automatic test_abort();
        bit found;
        run = 1'b0;
        cyc();
        cyc();
        period_div = 11'd7;
        run = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abort_run cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
            if (m_age == 2) found = 1;
        end
        checks++;
        if (!found || mult_en !== 1'b1 || mult_sel !== 1'b0) begin
            errors++;
            $display("FAIL abort_mul1: got mult_en=%b mult_sel=%b want 1 0", mult_en, mult_sel);
        end
        run = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            checks++;
            if ({tick, sub_en, mult_en, mult_sel, add_en, dout_valid} !== 6'b0) begin
                errors++;
                $display("FAIL abort_ctrl cyc %0d: got %b want 000000", cycle_n,
                         {tick, sub_en, mult_en, mult_sel, add_en, dout_valid});
            end
        end
        run = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc();
            if (m_age == 3) found = 1;
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (!found || obs_vec() !== 30'b0) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", obs_vec(), 30'b0);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int gap_left;
        gap_left = $urandom_range(10, 1000);
        for (int k = 0; k < 14000; k++) begin
            din_strobe = (gap_left == 0);
            if (gap_left == 0) begin
                gap_left = ($urandom_range(0, 15) == 0) ? $urandom_range(1100, 2600)
                                                        : $urandom_range(1021, 1027);
            end else begin
                gap_left--;
            end
            err_clr = ($urandom_range(0, 63) == 0);
            if (run && $urandom_range(0, 1499) == 0) begin
                run = 1'b0;
            end else if (!run && $urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: period_div = 11'd2;
                    1: period_div = 11'd15;
                    2: period_div = 11'h1FF;
                    default: period_div = 11'($urandom_range(3, 700));
                endcase
                run = 1'b1;
            end
            cyc();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", cycle_n, obs_vec(), exp_vec());
            end
        end
        din_strobe = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ticks();
        test_lock();
        test_phase();
        test_overrun();
        test_saturate();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
